rv32_wb_sched: RTL

- Write-back scheduler and hazard controller for the rv32 register file.
- Tracks registers with outstanding long-latency (load) results in a scoreboard.
- Stalls decode on RAW/WAW hazards.
- Arbitrates the single regfile write port between the in-order ALU write-back and asynchronous load returns; load returns go through a one-entry buffer.
- Sits between decode, the ALU write-back stage, the load unit and rv32_regs; drives the regfile stall and write ports.

---
 rtl/rv32_sched_pkg.sv | 22 ++
 rtl/rv32_wb_skid.sv | 28 ++
 rtl/rv32_wb_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv32_sched_pkg.sv
// rtl/rv32_sched_pkg.sv - shared widths, write-back request type and clog2 helper
package rv32_sched_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
    logic                  valid;
  } wb_req_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32_wb_skid.sv
// rtl/rv32_wb_skid.sv - one-entry load-return buffer with drain strobe
module rv32_wb_skid
  import rv32_sched_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  wb_req_t in_req,
  output logic    in_ready,
  input  logic    port_free,
  output wb_req_t buf_req,
  output logic    drained
);

  assign in_ready = !buf_req.valid;
  assign drained  = buf_req.valid && port_free;

  // Capture and drain are mutually exclusive: capture needs an empty buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_req <= '0;
    end else if (in_req.valid && in_ready) begin
      buf_req <= in_req;
    end else if (drained) begin
      buf_req.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rv32_wb_sched.sv
// rtl/rv32_wb_sched.sv - write-back scheduler and hazard controller (RV32_WB_SCHED_FWD_EN enables buffer forwarding)
module rv32_wb_sched
  import rv32_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_WAIT        = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic                  rs1_read_in,
  input  logic                  rs2_read_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  rd_write_in,
  input  logic                  long_in,
  input  logic [REG_ADDR_W-1:0] alu_rd_in,
  input  logic                  alu_write_in,
  input  logic [XLEN-1:0]       alu_value_in,
  input  logic [REG_ADDR_W-1:0] mem_rd_in,
  input  logic                  mem_valid_in,
  input  logic [XLEN-1:0]       mem_value_in,
  output logic                  mem_ready_out,
  output logic                  stall_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  rd_write_out,
  output logic [XLEN-1:0]       rd_value_out,
  output logic                  rs1_fwd_out,
  output logic                  rs2_fwd_out,
  output logic [XLEN-1:0]       fwd_value1_out,
  output logic [XLEN-1:0]       fwd_value2_out
);

  localparam int WAIT_W = clog2(MAX_WAIT + 1);

  logic [31:0]       pending;
  logic [3:0]        outstanding;
  logic [WAIT_W-1:0] wait_cnt;
  wb_req_t           load_req;
  wb_req_t           buf_req;
  logic              load_keep;
  logic              alu_grant;
  logic              drained;
  logic              fwd1;
  logic              fwd2;
  logic              set_en;
  logic [31:0]       retire_mask;
  logic [31:0]       set_mask;

  // Returns to a non-pending register (or x0) are accepted but never buffered.
  assign load_keep = (mem_rd_in != '0) && pending[mem_rd_in];
  assign load_req  = '{rd: mem_rd_in, value: mem_value_in, valid: mem_valid_in && load_keep};
  assign alu_grant = alu_write_in && (alu_rd_in != '0);

  rv32_wb_skid u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_req    (load_req),
    .in_ready  (mem_ready_out),
    .port_free (!alu_grant),
    .buf_req   (buf_req),
    .drained   (drained)
  );

`ifdef RV32_WB_SCHED_FWD_EN
  assign fwd1 = buf_req.valid && rs1_read_in && (rs1_in != '0) && (rs1_in == buf_req.rd);
  assign fwd2 = buf_req.valid && rs2_read_in && (rs2_in != '0) && (rs2_in == buf_req.rd);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign rs1_fwd_out    = fwd1;
  assign rs2_fwd_out    = fwd2;
  assign fwd_value1_out = fwd1 ? buf_req.value : '0;
  assign fwd_value2_out = fwd2 ? buf_req.value : '0;

  always_comb begin
    rd_write_out = 1'b0;
    rd_out       = '0;
    rd_value_out = '0;
    retire_mask  = '0;
    if (alu_grant) begin
      rd_write_out = 1'b1;
      rd_out       = alu_rd_in;
      rd_value_out = alu_value_in;
    end else if (drained) begin
      rd_write_out = 1'b1;
      rd_out       = buf_req.rd;
      rd_value_out = buf_req.value;
      retire_mask  = 32'd1 << buf_req.rd;
    end
  end

  // A retiring write resolves a WAW hazard in the same cycle, so reissue to it may proceed.
  always_comb begin
    stall_out = 1'b0;
    if (rs1_read_in && pending[rs1_in] && !fwd1) stall_out = 1'b1;
    if (rs2_read_in && pending[rs2_in] && !fwd2) stall_out = 1'b1;
    if (rd_write_in && pending[rd_in] && !retire_mask[rd_in]) stall_out = 1'b1;
    if (long_in && rd_write_in && (outstanding == 4'(MAX_OUTSTANDING))) stall_out = 1'b1;
    if (wait_cnt == WAIT_W'(MAX_WAIT)) stall_out = 1'b1;
  end

  assign set_en   = rd_write_in && !stall_out && long_in && (rd_in != '0);
  assign set_mask = set_en ? (32'd1 << rd_in) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending     <= '0;
      outstanding <= '0;
      wait_cnt    <= '0;
    end else begin
      pending <= ((pending & ~retire_mask) | set_mask) & 32'hFFFF_FFFE;
      if (set_en && !drained) begin
        assert (outstanding < 4'(MAX_OUTSTANDING))
          else $error("rv32_wb_sched: outstanding overflow");
        outstanding <= outstanding + 4'd1;
      end else if (!set_en && drained) begin
        outstanding <= outstanding - 4'd1;
      end
      if (!buf_req.valid || drained) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      assert (!(mem_valid_in && mem_ready_out && !load_keep))
        else $error("rv32_wb_sched: load return to non-pending register %0d", mem_rd_in);
    end
  end

endmodule
